fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  taken branch/jump from execute; flush.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port dec_valid  output  1  instruction available to decode stage.
REQ-013 SHALL have port dec_instr  output  32  head-of-FIFO instruction.
REQ-014 SHALL have port dec_pc  output  32  PC of dec_instr.
REQ-015 SHALL have port dec_opcode  output  7  dec_instr[6:0], drives main decoder opcode input.
REQ-016 SHALL have port dec_ready  input  1  decode consumes head (inverse of decode stall).
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 SHALL accept a request on a cycle where imem_req_valid and imem_req_ready are both 1 (a "fire").
REQ-019 SHALL assume fixed one-cycle memory latency: imem_rsp_valid/imem_rsp_data arrive exactly one cycle after each fire; at most one request in flight.
REQ-020 SHALL assert imem_req_valid only when count + inflight + 0 < DEPTH after accounting for a same-cycle pop, reset is low, and redirect_valid is 0 (credit rule; FIFO never overflows).
REQ-021 SHALL drive imem_req_addr from fetch-PC register; fetch PC SHALL advance by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0) on each fire.
REQ-022 SHALL push {pc, instr} into FIFO on an undropped imem_rsp_valid; pc is the address of the matching request.
REQ-023 SHALL drive dec_valid = (count != 0); dec_instr/dec_pc/dec_opcode from head entry, no bypass (response visible at earliest the cycle after it arrives).
REQ-024 SHALL pop head when dec_valid and dec_ready are both 1; dec_ready while empty has no effect.
REQ-025 SHALL leave count unchanged on simultaneous push and pop, including when full.
REQ-026 SHALL hold head stable while dec_valid and not dec_ready.
REQ-027 On redirect_valid: same edge SHALL clear FIFO (count=0), load fetch PC with {redirect_pc[31:2],2'b00}, suppress this cycle's request and pop, and set drop flag if a request is in flight.
REQ-028 SHALL discard the response arriving while drop flag is set, then clear drop flag; first request to the redirect target issues the cycle after redirect.
REQ-029 SHALL give redirect priority over push, pop and fire in the same cycle.
REQ-030 SHALL treat redirect_valid on consecutive cycles as successive redirects; last one wins.
REQ-031 SHALL have throughput of one instruction per cycle in steady state with dec_ready held 1.

Reset
REQ-032 While reset high: imem_req_valid=0, dec_valid=0, count=0, fetch PC=RESET_PC, drop flag=0, inflight=0, dec_instr/dec_pc=0.
REQ-033 Reset assertion mid-operation SHALL abandon any in-flight response; response arriving in the first cycle after deassertion is ignored unless requested after deassertion.
REQ-034 First fire SHALL be possible in the first cycle after reset deassertion; first dec_valid two cycles later.

Verification
REQ-035 Reset release, imem_req_ready=1, dec_ready=1, memory returns 32'h00000013 -> addresses 0,4,8 on cycles 0,1,2; dec_valid from cycle 2, dec_pc 0,4,8, dec_opcode 7'h13.
REQ-036 dec_ready=0 with DEPTH=4 -> exactly four fires, count reaches 4, imem_req_valid stays 0; dec_ready=1 one cycle -> one pop, one new fire.
REQ-037 Full FIFO, push and pop same cycle -> count stays 4, head advances by one entry, no data lost.
REQ-038 Redirect to 32'h0000_0102 with response in flight -> FIFO empties, in-flight word dropped, next request address 32'h0000_0100, its instruction next appears with dec_pc 32'h0000_0100.
REQ-039 Fetch PC at 32'hFFFF_FFFC -> next request address 32'h0000_0000.
REQ-040 Reset asserted with count=3 and request in flight -> all outputs at reset values immediately; after release fetch restarts at RESET_PC with no stale instruction on dec_instr.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues word-aligned fetches under a FIFO credit rule,
// captures one-cycle-latency responses with their PC, and presents the head to decode.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     dec_valid,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_pc,
  output logic [6:0]               dec_opcode,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic          drop_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          pop;
  logic          push;
  logic          fire;
  logic [CW:0]   credit_used;

  // Handshakes, credit accounting and head presentation.
  always_comb begin
    pop            = (count_q != '0) && dec_ready && !redirect_valid;
    push           = imem_rsp_valid && inflight_q && !drop_q && !redirect_valid;
    credit_used    = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req_valid = !reset && !redirect_valid && !drop_q &&
                     (credit_used < (CW+1)'(DEPTH));
    fire           = imem_req_valid && imem_req_ready;
    imem_req_addr  = fetch_pc_q;
    dec_valid      = (count_q != '0);
    dec_instr      = dec_valid ? instr_mem[rd_ptr_q] : 32'h0;
    dec_pc         = dec_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    dec_opcode     = dec_instr[6:0];
    count          = count_q;
  end

  // Fetch PC, in-flight tracking and FIFO pointers; redirect overrides everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
      inflight_q <= 1'b0;
      // A response still owed after this edge belongs to the old path.
      drop_q     <= inflight_q && !imem_rsp_valid;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= fire;
      if (imem_rsp_valid) drop_q <= 1'b0;
      if (fire) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        req_pc_q   <= fetch_pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; occupancy gating makes stale contents invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer with a one-cycle-latency memory responder.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic        dec_ready;
  logic [2:0]  count;

  int vectors = 0;
  int errors  = 0;
  int fire_cnt = 0;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_ready(dec_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction word the memory returns for an address (opcode is always 7'h13).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) | 32'h0000_0013;
  endfunction

  // Advance one cycle; the memory answers the fire seen before the edge.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = imem_req_valid & imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = f;
    imem_rsp_data  = f ? mem_word(a) : 32'h0;
    if (f) fire_cnt++;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    fire_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
    @(posedge clk); #2;
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    vectors++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr got %h want 0", dec_instr); end
    vectors++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h want 0", dec_pc); end
    vectors++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    dec_ready = 1'b1; #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL stream_c0 got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    tick();
    vectors++; if (imem_req_addr !== 32'h4 || dec_valid !== 1'b0) begin errors++; $display("FAIL stream_c1 got a=%h dv=%b want a=4 dv=0", imem_req_addr, dec_valid); end
    tick();
    vectors++; if (imem_req_addr !== 32'h8 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin errors++; $display("FAIL stream_c2 got a=%h dv=%b pc=%h want a=8 dv=1 pc=0", imem_req_addr, dec_valid, dec_pc); end
    vectors++; if (dec_instr !== 32'h0000_0013 || dec_opcode !== 7'h13) begin errors++; $display("FAIL stream_instr got %h/%h want 00000013/13", dec_instr, dec_opcode); end
    for (int k = 3; k < 9; k++) begin
      tick();
      vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (k - 2)) || count !== 3'd1) begin errors++; $display("FAIL stream_tput c%0d got dv=%b pc=%h cnt=%0d want dv=1 pc=%h cnt=1", k, dec_valid, dec_pc, count, 32'(4 * (k - 2))); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    dec_ready = 1'b0; #1;
    repeat (8) tick();
    vectors++; if (fire_cnt != 4) begin errors++; $display("FAIL bp_fires got %0d want 4", fire_cnt); end
    vectors++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d want 4", count); end
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid); end
    vectors++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL bp_head_hold got pc=%h i=%h want pc=0 i=00000013", dec_pc, dec_instr); end
    dec_ready = 1'b1; #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_pop_credit got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
    tick();
    dec_ready = 1'b0; #1;
    vectors++; if (count !== 3'd3 || dec_pc !== 32'h4) begin errors++; $display("FAIL bp_one_pop got cnt=%0d pc=%h want cnt=3 pc=4", count, dec_pc); end
    tick();
    vectors++; if (count !== 3'd4 || imem_req_valid !== 1'b0 || fire_cnt != 5) begin errors++; $display("FAIL bp_refill got cnt=%0d v=%b fires=%0d want cnt=4 v=0 fires=5", count, imem_req_valid, fire_cnt); end
  endtask

  task automatic test_full_drain();
    dec_ready = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      vectors++; if (dec_pc !== 32'(4 + 4 * k) || dec_instr !== mem_word(32'(4 + 4 * k)) || count !== ((k == 0) ? 3'd4 : 3'd3)) begin
        errors++; $display("FAIL drain k=%0d got pc=%h i=%h cnt=%0d want pc=%h i=%h cnt=%0d", k, dec_pc, dec_instr, count, 32'(4 + 4 * k), mem_word(32'(4 + 4 * k)), (k == 0) ? 4 : 3);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #1;
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_suppress got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (count !== 3'd0 || dec_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got cnt=%0d dv=%b want 0/0", count, dec_valid); end
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_target got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    tick();
    vectors++; if (dec_valid !== 1'b0 || imem_req_addr !== 32'h0000_0104) begin errors++; $display("FAIL redir_drop got dv=%b a=%h want dv=0 a=00000104", dec_valid, imem_req_addr); end
    tick();
    vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0000_0100 || dec_instr !== 32'h0000_2013) begin errors++; $display("FAIL redir_first got dv=%b pc=%h i=%h want 1/00000100/00002013", dec_valid, dec_pc, dec_instr); end
  endtask

  task automatic test_back_to_back_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    tick();
    redirect_pc = 32'h0000_0303; #1;
    vectors++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0000_0200) begin errors++; $display("FAIL b2b_mid got v=%b a=%h want v=0 a=00000200", imem_req_valid, imem_req_addr); end
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (imem_req_addr !== 32'h0000_0300 || count !== 3'd0) begin errors++; $display("FAIL b2b_last got a=%h cnt=%0d want a=00000300 cnt=0", imem_req_addr, count); end
    tick(); tick();
    vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0000_0300) begin errors++; $display("FAIL b2b_dec got dv=%b pc=%h want 1/00000300", dec_valid, dec_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h want fffffffc", imem_req_addr); end
    tick();
    vectors++; if (imem_req_addr !== 32'h0000_0000 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_next got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    tick();
    vectors++; if (dec_pc !== 32'hFFFF_FFFC || dec_instr !== 32'hFFFF_FF93) begin errors++; $display("FAIL wrap_dec got pc=%h i=%h want fffffffc/ffffff93", dec_pc, dec_instr); end
    tick();
    vectors++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL wrap_dec0 got pc=%h i=%h want 0/00000013", dec_pc, dec_instr); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    dec_ready = 1'b0; #1;
    repeat (4) tick();
    vectors++; if (count !== 3'd3 || imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got cnt=%0d rsp=%b want 3/1", count, imem_rsp_valid); end
    #1; reset = 1'b1; #1;
    vectors++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_reset_ctl got v=%b dv=%b cnt=%0d want 0/0/0", imem_req_valid, dec_valid, count); end
    vectors++; if (dec_instr !== 32'h0 || dec_pc !== 32'h0 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_data got i=%h pc=%h a=%h want 0/0/0", dec_instr, dec_pc, imem_req_addr); end
    @(posedge clk); #1;
    reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; dec_ready = 1'b1; #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    tick();
    vectors++; if (dec_valid !== 1'b0 || count !== 3'd0 || imem_req_addr !== 32'h4) begin errors++; $display("FAIL mid_stale got dv=%b cnt=%0d a=%h want 0/0/4", dec_valid, count, imem_req_addr); end
    tick();
    vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL mid_first got dv=%b pc=%h i=%h want 1/0/00000013", dec_valid, dec_pc, dec_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_drain();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", vectors);
    $fatal(1, "timeout");
  end

endmodule
